imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
//
// PURPOSE
//   Parametrised, pipelined immediate-extension unit for the multi-cycle and pipelined MIPS datapaths.
//   Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes:
//     zero, sign, upper (LUI) or branch-offset.
//   Carries a valid/ready handshake through a registered output stage plus a 1-entry skid register.
//   Sits between decode and the ALU-operand mux; one result per cycle at full throughput.
//
// PARAMETERS
//   IN_W       16   immediate width; legal range 2 <= IN_W <= OUT_W
//   OUT_W      32   extended result width
//   SHIFT_AMT  16   left shift for mode 2 (LUI); legal range 0 <= SHIFT_AMT < OUT_W
//
// PORTS
//   clock      in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   in_valid   in   1       entrada/modo valid this cycle
//   in_ready   out  1       unit can accept; transfer = in_valid & in_ready
//   entrada    in   IN_W    raw immediate
//   modo       in   2       00 zero, 01 sign, 10 upper, 11 branch offset
//   out_valid  out  1       saida valid
//   out_ready  in   1       consumer accepts; transfer = out_valid & out_ready
//   saida      out  OUT_W   extended immediate
//   nivel      out  2       occupancy, 0..2 (output reg + skid reg)
//
// BEHAVIOUR
//   Extension function f(entrada, modo):
//     00: {(OUT_W-IN_W) zeros, entrada}
//     01: {(OUT_W-IN_W) copies of entrada[IN_W-1], entrada}
//     10: zero-extended entrada << SHIFT_AMT, truncated to OUT_W (bits lost off the top are dropped)
//     11: sign-extended entrada << 2, truncated to OUT_W
//   f is evaluated at acceptance; only extended values are stored, never raw inputs.
//   Storage: output reg (OR) drives saida/out_valid; skid reg (SK) holds one extra result.
//   in_ready = ~SK.valid. It depends only on state, never combinationally on out_ready.
//   Each cycle, with acc = in_valid & in_ready and pop = out_valid & out_ready:
//     OR empty, acc            -> OR <= f(in)
//     OR full, pop, SK full    -> OR <= SK; SK <= empty (acc impossible)
//     OR full, pop, SK empty   -> OR <= f(in) if acc, else OR empty
//     OR full, no pop, acc     -> SK <= f(in)
//     otherwise                -> hold
//   Latency: accepted in cycle N -> visible on saida in cycle N+1 when OR was empty or popped in N.
//   Ordering: strict FIFO; no result is dropped or duplicated.
//   saida holds its last value while out_valid=0. It must be stable while out_valid & ~out_ready.
//   nivel = OR.valid + SK.valid.
//     nivel=2 <=> in_ready=0 (full).
//     nivel=0 <=> out_valid=0 (empty).
//   Simultaneous acc and pop at nivel=1 leaves nivel=1, throughput 1/cycle.
//   Reset (asserted any time, including mid-transfer):
//     out_valid=0, saida=0, nivel=0, in_ready=1, SK cleared; in-flight results are discarded.
//     The first accept is possible on the first clock edge after reset deasserts.
//
// TESTING
//   1. Mode 01, entrada=16'h8001, out_ready=1 -> next cycle saida=32'hFFFF8001, out_valid=1.
//      Modes 00/10 with the same entrada -> 32'h00008001 / 32'h80010000.
//   2. Mode 11, entrada=16'hFFFF -> 32'hFFFFFFFC; entrada=16'h0004 -> 32'h00000010.
//   3. out_ready=0, push A=16'h0001 then B=16'h0002 (mode 00) -> nivel=2, in_ready=0, C held off.
//      Raise out_ready -> saida 1, 2, then C on consecutive cycles.
//   4. Streaming 8 values with in_valid=out_ready=1 -> 8 results in order, one per cycle.
//      nivel stays 1, in_ready never drops.
//   5. Reset asserted with nivel=2 -> immediately out_valid=0, saida=0, nivel=0, in_ready=1.
//      After release, a new input appears one cycle after acceptance.
//   6. Parameter sweep IN_W=8, OUT_W=16, SHIFT_AMT=8:
//      mode 01, entrada=8'h80 -> 16'hFF80; mode 10, entrada=8'hAB -> 16'hAB00.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (zero / sign / upper / branch-offset) behind a
// valid/ready handshake with a registered output stage and a one-entry skid register.
module imm_extend_pipe #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned SHIFT_AMT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  entrada,
    input  logic [1:0]       modo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] saida,
    output logic [1:0]       nivel
);

    logic             r_or_valid;
    logic [OUT_W-1:0] r_or_data;
    logic             r_sk_valid;
    logic [OUT_W-1:0] r_sk_data;
    logic [1:0]       r_nivel;
    logic             r_in_ready;

    logic             w_or_valid_nxt;
    logic [OUT_W-1:0] w_or_data_nxt;
    logic             w_sk_valid_nxt;
    logic [OUT_W-1:0] w_sk_data_nxt;
    logic             w_acc;
    logic             w_pop;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;

    assign w_acc = in_valid & r_in_ready;
    assign w_pop = r_or_valid & out_ready;

    // Extension is done at acceptance so only final results are ever stored.
    always_comb begin
        w_zext = OUT_W'(entrada);
        w_sext = OUT_W'($signed(entrada));
        w_ext  = w_zext;
        case (modo)
            2'b00:   w_ext = w_zext;
            2'b01:   w_ext = w_sext;
            2'b10:   w_ext = w_zext << SHIFT_AMT;
            default: w_ext = w_sext << 2;
        endcase
    end

    always_comb begin
        w_or_valid_nxt = r_or_valid;
        w_or_data_nxt  = r_or_data;
        w_sk_valid_nxt = r_sk_valid;
        w_sk_data_nxt  = r_sk_data;
        if (!r_or_valid) begin
            if (w_acc) begin
                w_or_valid_nxt = 1'b1;
                w_or_data_nxt  = w_ext;
            end
        end else if (w_pop) begin
            if (r_sk_valid) begin
                w_or_data_nxt  = r_sk_data;
                w_sk_valid_nxt = 1'b0;
            end else if (w_acc) begin
                w_or_data_nxt  = w_ext;
            end else begin
                w_or_valid_nxt = 1'b0;
            end
        end else if (w_acc) begin
            w_sk_valid_nxt = 1'b1;
            w_sk_data_nxt  = w_ext;
        end
    end

    // Occupancy and ready are registered alongside the storage they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_nivel    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_or_valid <= w_or_valid_nxt;
            r_or_data  <= w_or_data_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            r_sk_data  <= w_sk_data_nxt;
            r_nivel    <= 2'(w_or_valid_nxt) + 2'(w_sk_valid_nxt);
            r_in_ready <= ~w_sk_valid_nxt;
        end
    end

    assign out_valid = r_or_valid;
    assign saida     = r_or_data;
    assign nivel     = r_nivel;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe against a queue-based reference model.
`timescale 1ns/1ps
module tb_imm_extend_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] entrada;
    logic [1:0]  modo, nivel;
    logic [31:0] saida;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_entrada;
    logic [1:0]  b_modo, b_nivel;
    logic [15:0] b_saida;

    int n_checks = 0;
    int n_errors = 0;

    longint unsigned q[$];
    longint unsigned last_out;

    always #5 clock = ~clock;

    imm_extend_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .entrada(entrada), .modo(modo), .out_valid(out_valid), .out_ready(out_ready),
        .saida(saida), .nivel(nivel)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .SHIFT_AMT(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .entrada(b_entrada), .modo(b_modo), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .saida(b_saida), .nivel(b_nivel)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference extension computed arithmetically from the mode rules.
    function automatic longint unsigned ref_f(input int iw, input int ow, input int sh,
                                              input longint unsigned e, input logic [1:0] m);
        longint unsigned mask, ev, sx;
        mask = (64'd1 << ow) - 64'd1;
        ev   = e & ((64'd1 << iw) - 64'd1);
        sx   = (ev >= (64'd1 << (iw - 1))) ? ev - (64'd1 << iw) : ev;
        case (m)
            2'd0:    return ev;
            2'd1:    return sx & mask;
            2'd2:    return (ev << sh) & mask;
            default: return (sx * 64'd4) & mask;
        endcase
    endfunction

    task automatic compare_model(input string tag);
        int n;
        n = q.size();
        check({tag, "_out_valid"}, 64'(out_valid), 64'(n > 0));
        check({tag, "_nivel"}, 64'(nivel), 64'(n));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(n < 2));
        check({tag, "_saida"}, 64'(saida), (n > 0) ? q[0] : last_out);
    endtask

    // One clock of the main DUT; inputs change after the falling edge, outputs checked at the next one.
    task automatic cycle(input string tag, input logic iv, input logic [1:0] md,
                         input logic [15:0] e, input logic ordy);
        logic m_acc, m_pop;
        in_valid = iv; modo = md; entrada = e; out_ready = ordy;
        m_acc = iv && (q.size() < 2);
        m_pop = (q.size() > 0) && ordy;
        @(posedge clock);
        if (m_pop) last_out = q.pop_front();
        if (m_acc) q.push_back(ref_f(16, 32, 16, 64'(e), md));
        @(negedge clock);
        compare_model(tag);
    endtask

    task automatic b_cycle(input logic [1:0] md, input logic [7:0] e, input longint unsigned exp,
                           input string tag);
        b_in_valid = 1'b1; b_modo = md; b_entrada = e; b_out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_valid"}, 64'(b_out_valid), 64'd1);
        check({tag, "_saida"}, 64'(b_saida), exp);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; entrada = '0; modo = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_entrada = '0; b_modo = '0; b_out_ready = 1'b0;
        q.delete(); last_out = 0;
        repeat (2) @(negedge clock);
        compare_model("rst");
        reset = 1'b0;

        // Mode coverage on the same immediate, then branch offsets.
        cycle("m01", 1'b1, 2'b01, 16'h8001, 1'b1); check("m01_const", 64'(saida), 64'hFFFF8001);
        cycle("m00", 1'b1, 2'b00, 16'h8001, 1'b1); check("m00_const", 64'(saida), 64'h00008001);
        cycle("m10", 1'b1, 2'b10, 16'h8001, 1'b1); check("m10_const", 64'(saida), 64'h80010000);
        cycle("m11a", 1'b1, 2'b11, 16'hFFFF, 1'b1); check("m11a_const", 64'(saida), 64'hFFFFFFFC);
        cycle("m11b", 1'b1, 2'b11, 16'h0004, 1'b1); check("m11b_const", 64'(saida), 64'h00000010);
        cycle("drain0", 1'b0, 2'b00, 16'h0000, 1'b1);
        check("empty_hold", 64'(saida), 64'h00000010);

        // Backpressure fills both stages and holds off C.
        cycle("bpA", 1'b1, 2'b00, 16'h0001, 1'b0);
        cycle("bpB", 1'b1, 2'b00, 16'h0002, 1'b0);
        check("bp_full_nivel", 64'(nivel), 64'd2);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        cycle("bpC_held", 1'b1, 2'b00, 16'h0003, 1'b0);
        check("bp_stable", 64'(saida), 64'd1);
        cycle("bp_pop1", 1'b1, 2'b00, 16'h0003, 1'b1); check("bp_seq2", 64'(saida), 64'd2);
        cycle("bp_pop2", 1'b1, 2'b00, 16'h0003, 1'b1); check("bp_seq3", 64'(saida), 64'd3);
        cycle("bp_drain", 1'b0, 2'b00, 16'h0000, 1'b1);

        // Full-throughput streaming.
        for (int i = 0; i < 8; i++) begin
            cycle("stream", 1'b1, 2'b00, 16'(16'h0100 + i), 1'b1);
            check("stream_nivel", 64'(nivel), 64'd1);
            check("stream_val", 64'(saida), 64'(16'h0100 + i));
        end
        cycle("stream_drain", 1'b0, 2'b00, 16'h0000, 1'b1);

        // Reset while full takes effect asynchronously.
        cycle("prerstA", 1'b1, 2'b01, 16'hABCD, 1'b0);
        cycle("prerstB", 1'b1, 2'b10, 16'h1234, 1'b0);
        #2 reset = 1'b1;
        #1;
        q.delete(); last_out = 0;
        compare_model("async_rst");
        @(negedge clock);
        reset = 1'b0;
        cycle("postrst", 1'b1, 2'b11, 16'h8000, 1'b1);
        check("postrst_val", 64'(saida), 64'hFFFE0000);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) cycle("rnd_drain", 1'b0, 2'b00, 16'h0000, 1'b1);

        // Narrow-parameter instance.
        b_cycle(2'b01, 8'h80, 64'hFF80, "p8_sext");
        b_cycle(2'b10, 8'hAB, 64'hAB00, "p8_upper");
        for (int i = 0; i < 20; i++) begin
            logic [1:0] m;
            logic [7:0] e;
            m = 2'($urandom);
            e = 8'($urandom);
            b_cycle(m, e, ref_f(8, 16, 8, 64'(e), m), "p8_rnd");
        end
        b_in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
